// File: rtl/sseg_score_display.sv
// rtl/sseg_score_display.sv - score to 4-digit multiplexed seven-segment display driver
//
// The binary score is clamped to 9999, converted to BCD by a sequential
// double-dabble engine, and latched into a display register only when the
// conversion has finished. A free-running scan then walks the four digits.

module sseg_score_display #(
    parameter int DATA_W         = 14,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        sseg_a_to_dp,
    output logic [3:0]        sseg_an,
    output logic              conv_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DATA_W-1:0] SAT_MAX    = DATA_W'(9999);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(SCAN_DIV - 1);

    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                force_q, force_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]   capt_q, capt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [15:0]         disp_q, disp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   clamped;
    logic                start;
    logic                last_shift;
    logic                load_en;
    logic                shift_en;
    logic                latch_en;
    logic [DATA_W+15:0]  shifted;

    // Adds 3 to every nibble that would overflow past 9 after the next shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Saturate the score and decide whether a new conversion is needed.
    always_comb begin
        clamped    = (data > SAT_MAX) ? SAT_MAX : data;
        start      = force_q || (clamped != shadow_q);
        last_shift = (cnt_q == LAST_SHIFT);
    end

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_CONV;
            S_CONV:  if (last_shift) state_d = S_LATCH;
            S_LATCH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: datapath strobes.
    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE:  load_en  = start;
            S_CONV:  shift_en = 1'b1;
            S_LATCH: latch_en = 1'b1;
            default: ;
        endcase
    end

    // Double-dabble datapath next-state: load, adjust-and-shift, latch.
    always_comb begin
        force_d  = force_q;
        work_d   = work_q;
        capt_d   = capt_q;
        shadow_d = shadow_q;
        bcd_d    = bcd_q;
        disp_d   = disp_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        shifted  = {bcd_adjust(bcd_q), work_q} << 1;

        if (load_en) begin
            work_d  = clamped;
            capt_d  = clamped;
            bcd_d   = 16'h0000;
            cnt_d   = '0;
            busy_d  = 1'b1;
            force_d = 1'b0;
        end

        if (shift_en) begin
            bcd_d  = shifted[DATA_W+15 -: 16];
            work_d = shifted[DATA_W-1:0];
            cnt_d  = cnt_q + 1'b1;
        end

        // The display only ever sees a finished conversion.
        if (latch_en) begin
            disp_d   = bcd_q;
            shadow_d = capt_q;
            busy_d   = 1'b0;
        end
    end

    // Datapath registers; reset forces a fresh conversion afterwards.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            force_q  <= 1'b1;
            work_q   <= '0;
            capt_q   <= '0;
            shadow_q <= '0;
            bcd_q    <= 16'h0000;
            disp_q   <= 16'h0000;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            force_q  <= force_d;
            work_q   <= work_d;
            capt_q   <= capt_d;
            shadow_q <= shadow_d;
            bcd_q    <= bcd_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign conv_busy = busy_q;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       pat;
    logic [3:0]       an_hot;

    // Prescaler and digit index advance.
    always_comb begin
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            pre_d = pre_q + 1'b1;
            idx_d = idx_q;
        end
    end

    // Digit select, leading-zero blanking, segment decode and polarity.
    always_comb begin
        nib   = disp_q[4*idx_q +: 4];
        blank = 1'b0;
        case (idx_q)
            2'd1:    blank = (disp_q[15:4]  == 12'h000);
            2'd2:    blank = (disp_q[15:8]  == 8'h00);
            2'd3:    blank = (disp_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        blank = blank && LZ_BLANK;

        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        if (blank) begin
            pat = 7'h00;
        end

        seg_d  = SEG_ACTIVE_LOW ? ~{1'b0, pat} : {1'b0, pat};
        an_hot = 4'b0001 << idx_q;
        an_d   = AN_ACTIVE_LOW ? ~an_hot : an_hot;
    end

    // Scan counters and registered display outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= 2'd0;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign sseg_a_to_dp = seg_q;
    assign sseg_an      = an_q;

endmodule

// File: tb/tb_sseg_score_display.sv
// tb/tb_sseg_score_display.sv - scoreboard bench for sseg_score_display

module tb_sseg_score_display;

    localparam int DATA_W   = 14;
    localparam int SCAN_DIV = 4;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_a, data_b;
    logic [7:0]        seg_a, seg_b;
    logic [3:0]        an_a, an_b;
    logic              busy_a, busy_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         sel;
        logic [3:0] an;
        logic [7:0] seg;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #10 sys_clk = ~sys_clk;

    sseg_score_display #(
        .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)
    ) u_dut (
        .sys_clk(sys_clk), .reset(reset), .data(data_a),
        .sseg_a_to_dp(seg_a), .sseg_an(an_a), .conv_busy(busy_a)
    );

    sseg_score_display #(
        .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
    ) u_nl (
        .sys_clk(sys_clk), .reset(reset), .data(data_b),
        .sseg_a_to_dp(seg_b), .sseg_an(an_b), .conv_busy(busy_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic [3:0] an_of(input int sel);
        return (sel != 0) ? an_b : an_a;
    endfunction

    function automatic logic [7:0] seg_of(input int sel);
        return (sel != 0) ? seg_b : seg_a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: decimal digits by division, active-low segments.
    function automatic logic [7:0] exp_seg(input int value, input int digit, input bit lz);
        logic [7:0] pats [10];
        int v, p, d;
        pats = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        v = (value > 9999) ? 9999 : value;
        p = 1;
        for (int i = 0; i < digit; i++) p = p * 10;
        d = (v / p) % 10;
        if (lz && digit > 0 && v < p) return 8'hFF;
        return ~pats[d];
    endfunction

    task automatic push_digit(input int sel, input int value, input bit lz, input int d, input string tag);
        exp_t e;
        logic [3:0] oh;
        oh    = 4'b0001 << d;
        e.sel = sel;
        e.an  = ~oh;
        e.seg = exp_seg(value, d, lz);
        e.tag = $sformatf("%s_d%0d", tag, d);
        sb.push_back(e);
    endtask

    task automatic push_expected(input int sel, input int value, input bit lz, input string tag);
        for (int d = 0; d < 4; d++) push_digit(sel, value, lz, d, tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_busy(input int sel, input logic level, input int budget, input string tag);
        int k;
        k = 0;
        while (busy_of(sel) !== level && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check(tag, busy_of(sel), level);
    endtask

    // Pops n expected digits and finds each one in the scan.
    task automatic scan_check(input int n, input int budget, input bit quiet, input string tag);
        exp_t e;
        int   k;
        logic saw_busy;
        saw_busy = 1'b0;
        @(negedge sys_clk);
        for (int j = 0; j < n; j++) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 1, 0);
            end else begin
                e = sb.pop_front();
                k = 0;
                while (an_of(e.sel) !== e.an && k < budget) begin
                    @(negedge sys_clk);
                    if (busy_of(e.sel)) saw_busy = 1'b1;
                    k++;
                end
                check({e.tag, "_an"}, an_of(e.sel), e.an);
                check({e.tag, "_seg"}, seg_of(e.sel), e.seg);
            end
        end
        if (quiet) check({tag, "_quiet"}, saw_busy, 1'b0);
    endtask

    logic [3:0] rec_an  [20];
    logic [7:0] rec_seg [20];
    logic [3:0] an_seq  [5];
    int         busy_cnt;

    initial begin
        an_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        reset  = 1'b1;
        data_a = '0;
        data_b = '0;
        step(3);
        check("rst_an", an_a, 4'hF);
        check("rst_seg", seg_a, 8'hFF);
        check("rst_busy", busy_a, 1'b0);
        check("rst_nl_an", an_b, 4'hF);

        // Release: forced conversion of 0 and the first scan rounds.
        reset    = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            rec_an[i]  = an_a;
            rec_seg[i] = seg_a;
            if (busy_a) busy_cnt++;
        end
        check("boot_busy_cycles", busy_cnt, DATA_W + 1);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("boot_an_slot%0d_first", s), rec_an[4*s], an_seq[s]);
            check($sformatf("boot_an_slot%0d_last", s), rec_an[4*s+3], an_seq[s]);
        end
        check("boot_seg_d0", rec_seg[0], 8'hC0);
        check("boot_seg_d1", rec_seg[4], 8'hFF);
        check("boot_seg_d2", rec_seg[8], 8'hFF);
        check("boot_seg_d3", rec_seg[12], 8'hFF);

        // Plain value.
        data_a = 14'd1234;
        push_expected(0, 1234, 1'b1, "v1234");
        wait_busy(0, 1'b1, 4, "v1234_start");
        wait_busy(0, 1'b0, 20, "v1234_done");
        scan_check(4, 24, 1'b1, "v1234");

        // Saturation at the top of the input range.
        data_a = 14'd16383;
        push_expected(0, 16383, 1'b1, "v16383");
        wait_busy(0, 1'b1, 4, "v16383_start");
        wait_busy(0, 1'b0, 20, "v16383_done");
        scan_check(4, 24, 1'b1, "v16383");

        // Clamps to the value already shown: no new conversion.
        data_a = 14'd10000;
        push_expected(0, 10000, 1'b1, "v10000");
        step(2);
        check("v10000_no_reconv", busy_a, 1'b0);
        scan_check(4, 24, 1'b1, "v10000");

        // Data change in the middle of a conversion.
        data_a = 14'h0005;
        push_digit(0, 5, 1'b1, 0, "mid5");
        wait_busy(0, 1'b1, 4, "mid_start");
        step(2);
        data_a = 14'h0042;
        push_expected(0, 'h42, 1'b1, "mid66");
        wait_busy(0, 1'b0, 20, "mid_first_done");
        step(1);
        check("mid_restart", busy_a, 1'b1);
        scan_check(1, 13, 1'b0, "mid5");
        wait_busy(0, 1'b0, 20, "mid_second_done");
        scan_check(4, 24, 1'b1, "mid66");

        // Leading zeros shown when blanking is disabled.
        data_b = 14'd7;
        push_expected(1, 7, 1'b0, "nl7");
        wait_busy(1, 1'b1, 4, "nl7_start");
        wait_busy(1, 1'b0, 20, "nl7_done");
        scan_check(4, 24, 1'b1, "nl7");

        // Reset in the middle of a conversion.
        data_a = 14'd999;
        wait_busy(0, 1'b1, 4, "r999_start");
        step(3);
        reset = 1'b1;
        step(1);
        check("r999_rst_an", an_a, 4'hF);
        check("r999_rst_seg", seg_a, 8'hFF);
        check("r999_rst_busy", busy_a, 1'b0);
        reset = 1'b0;
        push_expected(0, 999, 1'b1, "r999");
        wait_busy(0, 1'b1, 2, "r999_restart");
        wait_busy(0, 1'b0, DATA_W + 2, "r999_done");
        scan_check(4, 24, 1'b1, "r999");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
